// File: rtl/jesd204_tx_pkg.sv
// rtl/jesd204_tx_pkg.sv - shared pattern modes, PRBS15 constants and step helper
package jesd204_tx_pkg;

  typedef enum logic [1:0] {
    RAMP    = 2'd0,
    PRBS15  = 2'd1,
    CONST   = 2'd2,
    CHECKER = 2'd3
  } pattern_mode_e;

  // x^15 + x^14 + 1: b[n] = b[n-14] ^ b[n-15]
  localparam int         PRBS15_LEN       = 15;
  localparam int         PRBS15_TAP       = 14;
  localparam logic [14:0] PRBS15_SEED_BASE = 15'h7FFF;
  localparam logic [7:0]  CHECKER_SEED     = 8'h55;

  // Per-lane seed; XOR with a small lane index keeps it non-zero.
  function automatic logic [14:0] prbs15_lane_seed(input int lane);
    return PRBS15_SEED_BASE ^ 15'(lane);
  endfunction

  // State holds the last 15 bits, state[14] oldest. Returns {next_state, data},
  // data[31] is the first generated bit.
  function automatic logic [46:0] prbs15_step32(input logic [14:0] state);
    logic [14:0] s;
    logic [31:0] d;
    s = state;
    d = '0;
    for (int k = 0; k < 32; k++) begin
      d[31-k] = s[PRBS15_LEN-1] ^ s[PRBS15_TAP-1];
      s       = {s[13:0], d[31-k]};
    end
    return {s, d};
  endfunction

endpackage

// File: rtl/jesd204_prbs15_lane.sv
// rtl/jesd204_prbs15_lane.sv - one lane of PRBS15, 8*OCTETS bits per beat
// Ports:
//   CLK, RESETn : link clock, async active-low reset (state returns to SEED)
//   load        : restart from SEED; data shows the seed beat this cycle
//   adv         : commit the beat on data and move to the following one
//   data        : next beat, octet o at [8o+7:8o], MSB of each octet earliest
module jesd204_prbs15_lane
  import jesd204_tx_pkg::*;
#(
  parameter int          OCTETS = 4,
  parameter logic [14:0] SEED   = PRBS15_SEED_BASE
) (
  input  logic                  CLK,
  input  logic                  RESETn,
  input  logic                  load,
  input  logic                  adv,
  output logic [8*OCTETS-1:0]   data
);

  localparam int W = 8 * OCTETS;

  logic [14:0] r_state;
  logic [14:0] w_s;
  logic [14:0] w_next_state;
  logic        w_bit;

  // Parallel unroll of the serial recurrence; octet 0 is earliest in time.
  always_comb begin
    w_s   = load ? SEED : r_state;
    w_bit = 1'b0;
    data  = '0;
    for (int k = 0; k < W; k++) begin
      w_bit = w_s[PRBS15_LEN-1] ^ w_s[PRBS15_TAP-1];
      data[8*(k/8) + 7 - (k%8)] = w_bit;
      w_s = {w_s[13:0], w_bit};
    end
    w_next_state = w_s;
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_state <= SEED;
    end else if (load || adv) begin
      r_state <= w_next_state;
    end
  end

endmodule

// File: rtl/jesd204_tx_pattern_gen.sv
// rtl/jesd204_tx_pattern_gen.sv - selectable test-pattern source for the JESD204 TX DI bus
// Ports:
//   CLK, RESETn : link clock, async active-low reset
//   EN, RDY     : a beat advances when both are high and no reload is pending
//   MODE        : requested pattern (RAMP/PRBS15/CONST/CHECKER)
//   CONST_VAL   : octet o of every lane in CONST mode, sampled on advance/reload
//   DI          : registered beat, [lane][octet][bit]
//   BEAT_CNT    : beats advanced since the last (re)load
//   MODE_ACT    : pattern currently on DI
module jesd204_tx_pattern_gen
  import jesd204_tx_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int OCTETS = 4
) (
  input  logic                                CLK,
  input  logic                                RESETn,
  input  logic                                EN,
  input  logic [1:0]                          MODE,
  input  logic [31:0]                         CONST_VAL,
  input  logic                                RDY,
  output logic [LANES-1:0][OCTETS-1:0][7:0]   DI,
  output logic [31:0]                         BEAT_CNT,
  output logic [1:0]                          MODE_ACT
);

  typedef logic [LANES-1:0][OCTETS-1:0][7:0] beat_t;

  localparam logic [7:0] RAMP_INC = 8'((LANES * OCTETS) % 256);

  function automatic beat_t ramp_seed();
    beat_t b;
    for (int l = 0; l < LANES; l++) begin
      for (int o = 0; o < OCTETS; o++) begin
        b[l][o] = 8'((l * OCTETS + o) % 256);
      end
    end
    return b;
  endfunction

  localparam beat_t RAMP_SEED = ramp_seed();

  beat_t         r_di;
  pattern_mode_e r_mode_act;
  logic [31:0]   r_beat_cnt;

  pattern_mode_e w_mode;
  logic          w_reload;
  logic          w_adv;
  logic          w_prbs_adv;
  beat_t         w_prbs;
  beat_t         w_const;
  beat_t         w_adv_beat;
  beat_t         w_seed_beat;

  assign w_mode     = pattern_mode_e'(MODE);
  assign w_reload   = (w_mode != r_mode_act);
  assign w_adv      = RDY & EN & ~w_reload;
  assign w_prbs_adv = w_adv & (r_mode_act == PRBS15);

  // Lanes are reloaded on every mode change so a return to PRBS restarts from seed.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    jesd204_prbs15_lane #(
      .OCTETS (OCTETS),
      .SEED   (prbs15_lane_seed(l))
    ) u_lane (
      .CLK    (CLK),
      .RESETn (RESETn),
      .load   (w_reload),
      .adv    (w_prbs_adv),
      .data   (w_prbs[l])
    );
  end

  always_comb begin
    w_const = '0;
    for (int l = 0; l < LANES; l++) begin
      for (int o = 0; o < OCTETS; o++) begin
        w_const[l][o] = CONST_VAL[8*(o%4) +: 8];
      end
    end
  end

  always_comb begin
    w_adv_beat  = r_di;
    w_seed_beat = RAMP_SEED;
    for (int l = 0; l < LANES; l++) begin
      for (int o = 0; o < OCTETS; o++) begin
        case (r_mode_act)
          RAMP:    w_adv_beat[l][o] = r_di[l][o] + RAMP_INC;
          CHECKER: w_adv_beat[l][o] = ~r_di[l][o];
          default: w_adv_beat[l][o] = r_di[l][o];
        endcase
        if (w_mode == CHECKER) begin
          w_seed_beat[l][o] = CHECKER_SEED;
        end
      end
    end
    case (r_mode_act)
      PRBS15:  w_adv_beat = w_prbs;
      CONST:   w_adv_beat = w_const;
      default: ;
    endcase
    // During a reload the lanes see load=1, so w_prbs is their seed beat.
    case (w_mode)
      PRBS15:  w_seed_beat = w_prbs;
      CONST:   w_seed_beat = w_const;
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_mode_act <= RAMP;
      r_di       <= RAMP_SEED;
      r_beat_cnt <= '0;
    end else if (w_reload) begin
      r_mode_act <= w_mode;
      r_di       <= w_seed_beat;
      r_beat_cnt <= '0;
    end else if (w_adv) begin
      r_di       <= w_adv_beat;
      r_beat_cnt <= r_beat_cnt + 32'd1;
    end
  end

  assign DI       = r_di;
  assign BEAT_CNT = r_beat_cnt;
  assign MODE_ACT = r_mode_act;

endmodule

// File: tb/tb_jesd204_tx_pattern_gen.sv
// tb/tb_jesd204_tx_pattern_gen.sv - self-checking bench for jesd204_tx_pattern_gen
module tb_jesd204_tx_pattern_gen;

  localparam int L   = 4;
  localparam int O   = 4;
  localparam int PER = 32767;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    en;
  logic                    rdy;
  logic [1:0]              mode;
  logic [31:0]             const_val;
  logic [L-1:0][O-1:0][7:0] di;
  logic [31:0]             beat_cnt;
  logic [1:0]              mode_act;

  always #5 clk = ~clk;

  jesd204_tx_pattern_gen #(.LANES(L), .OCTETS(O)) dut (
    .CLK       (clk),
    .RESETn    (rst_n),
    .EN        (en),
    .MODE      (mode),
    .CONST_VAL (const_val),
    .RDY       (rdy),
    .DI        (di),
    .BEAT_CNT  (beat_cnt),
    .MODE_ACT  (mode_act)
  );

  int          total = 0;
  int          bad   = 0;
  int          m_act;
  longint      m_n;
  logic [31:0] m_const;
  int          zero_beats;
  logic [127:0] frozen_di;
  logic [31:0]  frozen_cnt;

  // One full period of each lane's serial bit stream; entries 0..14 are the seed history.
  bit pstream [L][PER+15];

  function automatic bit pbit(input int l, input longint k);
    return pstream[l][15 + int'(k % PER)];
  endfunction

  function automatic logic [127:0] exp_di();
    logic [127:0] r;
    logic [7:0]   v;
    r = '0;
    for (int l = 0; l < L; l++) begin
      for (int o = 0; o < O; o++) begin
        v = '0;
        case (m_act)
          0: v = 8'((l * O + o + 16 * m_n) % 256);
          1: for (int j = 0; j < 8; j++) v[7-j] = pbit(l, 32 * m_n + 8 * o + j);
          2: v = m_const[8*o +: 8];
          default: v = m_n[0] ? 8'hAA : 8'h55;
        endcase
        r[(l*O+o)*8 +: 8] = v;
      end
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_di"}, di, exp_di());
    check({tag, "_cnt"}, 128'(beat_cnt), 128'(m_n[31:0]));
    check({tag, "_mode"}, 128'(mode_act), 128'(m_act[1:0]));
  endtask

  // Advance the reference by one clock using the inputs currently applied.
  task automatic step();
    if (!rst_n) begin
      m_act = 0;
      m_n   = 0;
    end else if (int'(mode) != m_act) begin
      m_act   = int'(mode);
      m_n     = 0;
      m_const = const_val;
    end else if (rdy && en) begin
      m_n++;
      m_const = const_val;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [14:0] seed;
    for (int l = 0; l < L; l++) begin
      seed = 15'h7FFF ^ 15'(l);
      for (int i = 0; i < 15; i++) pstream[l][i] = seed[14-i];
      for (int i = 15; i < PER + 15; i++) pstream[l][i] = pstream[l][i-14] ^ pstream[l][i-15];
    end

    rst_n = 1'b0; en = 1'b0; rdy = 1'b0; mode = 2'd0; const_val = '0;
    m_act = 0; m_n = 0; m_const = '0;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    check("reset_lane0", 128'(di[0]), 128'h03020100);
    check("reset_lane3", 128'(di[3]), 128'h0F0E0D0C);

    // RAMP advance and wrap
    rst_n = 1'b1; en = 1'b1; rdy = 1'b1;
    repeat (3) begin step(); check_all("ramp"); end
    check("ramp3_oct0", 128'(di[0][0]), 128'h30);
    check("ramp3_cnt", 128'(beat_cnt), 128'd3);
    repeat (13) begin step(); check_all("ramp"); end
    check("ramp16_wrap", 128'(di[0][0]), 128'h00);

    // PRBS15 with random RDY/EN, then a full-period run
    mode = 2'd1;
    step(); check_all("prbs_seed");
    total++;
    assert (di[0] !== di[1]) else begin
      bad++;
      $error("FAIL prbs_lanes_differ observed=%h expected_not=%h", di[0], di[1]);
    end
    repeat (300) begin
      rdy = 1'($urandom % 2);
      en  = ($urandom % 4) != 0;
      step(); check_all("prbs_rand");
    end
    rdy = 1'b1; en = 1'b1; zero_beats = 0;
    repeat (32768) begin
      step(); check_all("prbs_run");
      for (int l = 0; l < L; l++) if (di[l] == '0) zero_beats++;
    end
    check("prbs_nozero", 128'(zero_beats), 128'd0);

    // RAMP 5 beats, then switch to CHECKER with RDY high
    mode = 2'd0;
    step(); check_all("ramp_reload");
    repeat (5) begin step(); check_all("ramp5"); end
    mode = 2'd3;
    step(); check_all("chk_reload");
    check("chk_seed", di, {16{8'h55}});
    check("chk_cnt0", 128'(beat_cnt), 128'd0);
    check("chk_mode", 128'(mode_act), 128'd3);
    step(); check_all("chk");
    check("chk_aa", 128'(di[2][1]), 128'hAA);
    repeat (4) begin step(); check_all("chk"); end

    // CONST: held until the next advance
    rdy = 1'b0; mode = 2'd2; const_val = 32'hDEADBEEF;
    step(); check_all("const_reload");
    repeat (3) begin
      const_val = $urandom;
      step(); check_all("const_hold");
      check("const_hold_lane3", 128'(di[3]), 128'hDEADBEEF);
    end
    rdy = 1'b1;
    step(); check_all("const_adv");
    repeat (20) begin
      const_val = $urandom;
      rdy = 1'($urandom % 2);
      step(); check_all("const_rand");
    end

    // EN low freezes PRBS mid-stream
    rdy = 1'b1; en = 1'b1; mode = 2'd1;
    step(); check_all("prbs2_reload");
    repeat (10) begin step(); check_all("prbs2"); end
    frozen_di = di; frozen_cnt = beat_cnt;
    en = 1'b0;
    repeat (4) begin step(); check_all("en_low"); end
    check("en_low_di", di, frozen_di);
    check("en_low_cnt", 128'(beat_cnt), 128'(frozen_cnt));
    en = 1'b1;
    repeat (10) begin step(); check_all("en_resume"); end

    // Async reset mid-stream, MODE stays PRBS15
    rst_n = 1'b0;
    #2;
    m_act = 0; m_n = 0;
    check_all("async_rst");
    check("async_rst_lane0", 128'(di[0]), 128'h03020100);
    #2;
    step(); check_all("rst_hold");
    rst_n = 1'b1;
    step(); check_all("rst_reload");
    check("rst_reload_mode", 128'(mode_act), 128'd1);
    repeat (5) begin step(); check_all("prbs3"); end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/jesd204_tx_pattern_gen.md
# jesd204_tx_pattern_gen

Upstream sample source for `jesd204_tx_env`, running in the link clock domain. It drives the parallel `DI` bus (lanes × octets) with a selectable test pattern: ramp, per-lane PRBS-15, constant, or checkerboard. It advances one beat per cycle in which the transmitter asserts `RDY`. It replaces the ad-hoc ramp counter in the top level and supplies deterministic, checkable traffic for link bring-up.

## Interface
Parameters:
- `LANES`, 4, number of JESD lanes.
- `OCTETS`, 4, octets per lane per `CLK` beat.

Ports:
- `CLK` in 1: link/sample clock, same clock as `jesd204_tx_env.CLK`.
- `RESETn` in 1: asynchronous active-low reset.
- `EN` in 1: pattern advance enable.
- `MODE` in 2: pattern select; 0 = RAMP, 1 = PRBS15, 2 = CONST, 3 = CHECKER.
- `CONST_VAL` in 32: octet pattern per lane for CONST; octet o = `CONST_VAL[8o+7:8o]`.
- `RDY` in 1: beat consumed by the transmitter (from `jesd204_tx_env.RDY`).
- `DI` out [LANES][OCTETS][8]: sample data to `jesd204_tx_env.DI`.
- `BEAT_CNT` out 32: beats advanced since the last (re)load.
- `MODE_ACT` out 2: mode currently driving `DI`.

## Operation
- Advance condition: `adv = RDY & EN & ~reload`. On `adv`, `DI` takes the next beat and `BEAT_CNT` increments (wraps at 2^32).
- Reload: `reload = (MODE != MODE_ACT)`. In the cycle after a reload, `MODE_ACT` is set to `MODE`, `DI` is set to the seed beat of the new mode, and `BEAT_CNT` is cleared. A reload takes priority over `adv`, so a `RDY` in the reload cycle does not advance.
- RAMP:
  - Seed octet (l,o) = l·OCTETS+o.
  - Each advance adds LANES·OCTETS to every octet, mod 256. With the defaults the increment is 16, which is identical to the legacy top-level counter.
- PRBS15:
  - Polynomial x^15+x^14+1 per lane, serial recurrence b[n] = b[n-14] ^ b[n-15].
  - Lane l state seed = 15'h7FFF ^ l (never zero).
  - Each beat is the next 8·OCTETS bits. Octet 0 is earliest in time, and the MSB of each octet is earliest.
  - The seed beat is the first 32 bits generated from the seed state.
- CONST: `DI` = `CONST_VAL` on every lane. `CONST_VAL` is sampled on each advance and on reload; it is not tracked combinationally.
- CHECKER:
  - Seed: every octet = 8'h55.
  - Each advance inverts all octets (55/AA alternation).
- `EN` low: `DI` and `BEAT_CNT` hold. A reload still occurs on a mode change.
- Reset values:
  - `MODE_ACT` = 0 and `DI` = RAMP seed.
  - `BEAT_CNT` = 0.
  - All PRBS states = lane seeds.
  - If `MODE` ≠ 0 when reset releases, a reload occurs in the first cycle.
- Reset mid-operation: all state returns to the reset values asynchronously. No partial beat is ever presented.

## Timing
- All outputs are registered; there is no combinational path from any input to `DI`.
- Advance latency: `RDY`&`EN` high in cycle n → new beat on `DI` in cycle n+1. Back-to-back `RDY` gives one new beat per cycle.
- Mode-change latency:
  - `MODE` changes in cycle n → seed on `DI` and new `MODE_ACT` in cycle n+1.
  - The first advance is possible from cycle n+1 (when `adv` is high in cycle n+1, the next beat appears in n+2).
- PRBS next-state is a 32-bit-per-beat parallel unroll, computed combinationally in one cycle. It contains no multi-cycle paths.

## Structure
- Shared package `jesd204_tx_pkg` holds:
  - `pattern_mode_e` (RAMP, PRBS15, CONST, CHECKER).
  - The PRBS15 polynomial/seed localparams.
  - The function `prbs15_step32(state) → {next_state, data[31:0]}`, shared with the checker in the receive-side bench.
- One sub-module is natural: `jesd204_prbs15_lane`, one instance per lane, with ports CLK, RESETn, `load`, `adv`, seed parameter, and `data[8·OCTETS-1:0]`.
- The top of the block holds the mode register, the reload logic, the `BEAT_CNT` counter and the output mux/register.

## Test plan
1. Reset with MODE=0, then `RDY`=`EN`=1 for 3 cycles.
   - After reset: lane0 = {03,02,01,00}, lane3 = {0F,0E,0D,0C}.
   - After 3 beats: lane0 octet0 = 8'h30; `BEAT_CNT`=3.
   - After 16 beats: octet0 wraps to 8'h00.
2. MODE=1, `RDY` high.
   - Each lane's bit stream matches the reference PRBS15 model from seed 7FFF^l.
   - Lanes 0 and 1 differ.
   - No all-zero lock-up over 2^15 beats.
3. Advance in RAMP for 5 beats, then switch MODE 0→3 in the same cycle as `RDY`=1.
   - Next cycle: `DI` = all 8'h55, `BEAT_CNT`=0, `MODE_ACT`=3, and no advance is taken.
   - Subsequent beats alternate AA/55.
4. MODE=2, `CONST_VAL`=32'hDEADBEEF, then change `CONST_VAL` without `RDY`.
   - `DI` holds {DE,AD,BE,EF} on all lanes until the next `RDY`.
5. Toggle `EN`=0 with `RDY`=1 for 4 cycles mid-PRBS.
   - `DI` and `BEAT_CNT` are frozen.
   - When `EN` returns, the sequence resumes exactly where it stopped.
6. Assert `RESETn` low mid-stream in PRBS mode while MODE stays 1.
   - `DI` returns to the RAMP seed immediately.
   - After release: reload, and the PRBS seed beat appears one cycle later.
